// File: rtl/exmem_reg.sv
// EX/MEM pipeline latch with data-cache request sequencing.
// Ports: CLK, nRST; en_in/flush_in advance control; dhit cache
//   completion; EX results (*_in) registered to *_out; dmemREN,
//   dmemWEN, dmemaddr, dmemstore cache request; mem_busy stall.
// Optional: EXMEM_FWD_EN adds fwd_valid, fwd_reg, fwd_data.
module exmem_reg (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        en_in,
    input  logic        flush_in,
    input  logic        dhit,
    input  logic [31:0] pcplus4_in,
    input  logic [31:0] aluOutport_in,
    input  logic [31:0] storedata_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic        MemToReg_in,
    input  logic        JType_in,
    input  logic        RegDst_in,
    input  logic        regWEN_in,
    input  logic        PcSrc_in,
    input  logic        JReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        halt_in,
    output logic [31:0] pcplus4_out,
    output logic [31:0] aluOutport_out,
    output logic [31:0] storedata_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic        MemToReg_out,
    output logic        JType_out,
    output logic        RegDst_out,
    output logic        regWEN_out,
    output logic        PcSrc_out,
    output logic        JReg_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic        halt_out,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_busy
`ifdef EXMEM_FWD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_data
`endif
);

    typedef struct packed {
        logic [31:0] pcplus4;
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        mem_to_reg;
        logic        jtype;
        logic        reg_dst;
        logic        reg_wen;
        logic        pc_src;
        logic        jreg;
        logic        mem_read;
        logic        mem_write;
        logic        halt;
    } exmem_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    exmem_t     ex_q;
    exmem_t     ex_d;
    mem_state_t state_q;
    mem_state_t state_d;
    logic       advance;
    logic       in_req;

    assign in_req   = (state_q == REQ);
    assign mem_busy = in_req & ~dhit;
    assign advance  = en_in & ~mem_busy & ~ex_q.halt;

    always_comb begin
        ex_d    = ex_q;
        state_d = state_q;
        if (advance) begin
            ex_d.pcplus4    = pcplus4_in;
            ex_d.alu_out    = aluOutport_in;
            ex_d.store_data = storedata_in;
            ex_d.rt         = rt_in;
            ex_d.rd         = rd_in;
            ex_d.mem_to_reg = MemToReg_in & ~flush_in;
            ex_d.jtype      = JType_in & ~flush_in;
            ex_d.reg_dst    = RegDst_in & ~flush_in;
            ex_d.reg_wen    = regWEN_in & ~flush_in;
            ex_d.pc_src     = PcSrc_in & ~flush_in;
            ex_d.jreg       = JReg_in & ~flush_in;
            ex_d.mem_read   = MemRead_in & ~flush_in;
            ex_d.mem_write  = MemWrite_in & ~flush_in;
            ex_d.halt       = halt_in & ~flush_in;
            if (~flush_in && (MemRead_in || MemWrite_in)) begin
                state_d = REQ;
            end else begin
                state_d = IDLE;
            end
        end else if (in_req && dhit && !ex_q.halt) begin
            // DONE blocks a second request for the same instruction
            state_d = DONE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_q    <= '0;
            state_q <= IDLE;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
        end
    end

    assign pcplus4_out    = ex_q.pcplus4;
    assign aluOutport_out = ex_q.alu_out;
    assign storedata_out  = ex_q.store_data;
    assign rt_out         = ex_q.rt;
    assign rd_out         = ex_q.rd;
    assign MemToReg_out   = ex_q.mem_to_reg;
    assign JType_out      = ex_q.jtype;
    assign RegDst_out     = ex_q.reg_dst;
    assign regWEN_out     = ex_q.reg_wen;
    assign PcSrc_out      = ex_q.pc_src;
    assign JReg_out       = ex_q.jreg;
    assign MemRead_out    = ex_q.mem_read;
    assign MemWrite_out   = ex_q.mem_write;
    assign halt_out       = ex_q.halt;

    assign dmemREN   = in_req & ex_q.mem_read;
    assign dmemWEN   = in_req & ex_q.mem_write;
    assign dmemaddr  = ex_q.alu_out;
    assign dmemstore = ex_q.store_data;

`ifdef EXMEM_FWD_EN
    always_comb begin
        fwd_reg = ex_q.reg_dst ? ex_q.rd : ex_q.rt;
        if (ex_q.jtype) begin
            fwd_reg = 5'd31;
        end
    end

    assign fwd_valid = ex_q.reg_wen & ~ex_q.mem_to_reg & (fwd_reg != 5'd0);
    assign fwd_data  = ex_q.jtype ? ex_q.pcplus4 : ex_q.alu_out;
`endif

endmodule

// File: tb/tb_exmem_reg.sv
// Bench for exmem_reg: random and directed stimulus, scoreboard
// of per-cycle expected outputs from a transaction-level model.
module tb_exmem_reg;

    typedef struct packed {
        logic        en;
        logic        flush;
        logic        dhit;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        m2r;
        logic        jt;
        logic        rdst;
        logic        wen;
        logic        pcs;
        logic        jr;
        logic        mr;
        logic        mw;
        logic        halt;
    } in_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        m2r;
        logic        jt;
        logic        rdst;
        logic        wen;
        logic        pcs;
        logic        jr;
        logic        mr;
        logic        mw;
        logic        halt;
    } regs_t;

    typedef struct packed {
        regs_t       r;
        logic        ren;
        logic        wen;
        logic        busy;
        logic        fv;
        logic [4:0]  freg;
        logic [31:0] fdata;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;
    in_t  vi;

    logic [31:0] pcplus4_out, aluOutport_out, storedata_out;
    logic [4:0]  rt_out, rd_out;
    logic MemToReg_out, JType_out, RegDst_out, regWEN_out;
    logic PcSrc_out, JReg_out, MemRead_out, MemWrite_out, halt_out;
    logic dmemREN, dmemWEN, mem_busy;
    logic [31:0] dmemaddr, dmemstore;
`ifdef EXMEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // model: the latched instruction, and whether its cache
    // access is still outstanding (not yet acknowledged by dhit)
    regs_t m_r;
    logic  m_pend;
    exp_t  sb_q[$];

    always #5 CLK = ~CLK;

    exmem_reg dut (
        .CLK(CLK), .nRST(nRST),
        .en_in(vi.en), .flush_in(vi.flush), .dhit(vi.dhit),
        .pcplus4_in(vi.pc), .aluOutport_in(vi.alu),
        .storedata_in(vi.sd), .rt_in(vi.rt), .rd_in(vi.rd),
        .MemToReg_in(vi.m2r), .JType_in(vi.jt),
        .RegDst_in(vi.rdst), .regWEN_in(vi.wen),
        .PcSrc_in(vi.pcs), .JReg_in(vi.jr),
        .MemRead_in(vi.mr), .MemWrite_in(vi.mw),
        .halt_in(vi.halt),
        .pcplus4_out(pcplus4_out), .aluOutport_out(aluOutport_out),
        .storedata_out(storedata_out), .rt_out(rt_out),
        .rd_out(rd_out), .MemToReg_out(MemToReg_out),
        .JType_out(JType_out), .RegDst_out(RegDst_out),
        .regWEN_out(regWEN_out), .PcSrc_out(PcSrc_out),
        .JReg_out(JReg_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .halt_out(halt_out),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_busy(mem_busy)
`ifdef EXMEM_FWD_EN
        ,
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
        .fwd_data(fwd_data)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.r    = m_r;
        e.busy = m_pend & ~vi.dhit;
        e.ren  = m_pend & m_r.mr;
        e.wen  = m_pend & m_r.mw;
        if (m_r.jt) e.freg = 5'd31;
        else        e.freg = m_r.rdst ? m_r.rd : m_r.rt;
        e.fv    = m_r.wen & ~m_r.m2r & (e.freg != 5'd0);
        e.fdata = m_r.jt ? m_r.pc : m_r.alu;
        return e;
    endfunction

    function automatic regs_t capture(input in_t x);
        regs_t r;
        r.pc = x.pc; r.alu = x.alu; r.sd = x.sd;
        r.rt = x.rt; r.rd = x.rd;
        r.m2r = x.m2r; r.jt = x.jt; r.rdst = x.rdst;
        r.wen = x.wen; r.pcs = x.pcs; r.jr = x.jr;
        r.mr = x.mr; r.mw = x.mw; r.halt = x.halt;
        if (x.flush) begin
            r.m2r = 0; r.jt = 0; r.rdst = 0; r.wen = 0;
            r.pcs = 0; r.jr = 0; r.mr = 0; r.mw = 0;
            r.halt = 0;
        end
        return r;
    endfunction

    // one clock cycle: apply inputs, log expectations, step model
    task automatic cyc(input in_t x);
        logic adv;
        vi = x;
        if (!nRST) begin
            m_r    = '0;
            m_pend = 1'b0;
        end
        sb_q.push_back(predict());
        @(posedge CLK);
        if (nRST && !m_r.halt) begin
            adv = x.en & ~(m_pend & ~x.dhit);
            if (adv) begin
                m_r    = capture(x);
                m_pend = ~x.flush & (x.mr | x.mw);
            end else if (m_pend && x.dhit) begin
                m_pend = 1'b0;
            end
        end
        #1;
    endtask

    function automatic in_t rnd();
        in_t x;
        x.en    = ($urandom_range(0, 3) != 0);
        x.flush = ($urandom_range(0, 6) == 0);
        x.dhit  = ($urandom_range(0, 4) < 2);
        x.pc    = $urandom;
        x.alu   = $urandom;
        x.sd    = $urandom;
        x.rt    = 5'($urandom);
        x.rd    = 5'($urandom);
        x.m2r   = 1'($urandom);
        x.jt    = 1'($urandom);
        x.rdst  = 1'($urandom);
        x.wen   = 1'($urandom);
        x.pcs   = 1'($urandom);
        x.jr    = 1'($urandom);
        x.mr    = ($urandom_range(0, 3) == 0);
        x.mw    = ($urandom_range(0, 3) == 0);
        x.halt  = ($urandom_range(0, 59) == 0);
        return x;
    endfunction

    always @(negedge CLK) begin
        exp_t  e;
        regs_t a;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            a.pc = pcplus4_out; a.alu = aluOutport_out;
            a.sd = storedata_out; a.rt = rt_out; a.rd = rd_out;
            a.m2r = MemToReg_out; a.jt = JType_out;
            a.rdst = RegDst_out; a.wen = regWEN_out;
            a.pcs = PcSrc_out; a.jr = JReg_out;
            a.mr = MemRead_out; a.mw = MemWrite_out;
            a.halt = halt_out;
            n_checks++;
            if (a !== e.r) begin
                n_fail++;
                $display("FAIL regs: got %h expected %h @%0t",
                         a, e.r, $time);
            end
            chk("dmemREN", 32'(dmemREN), 32'(e.ren));
            chk("dmemWEN", 32'(dmemWEN), 32'(e.wen));
            chk("mem_busy", 32'(mem_busy), 32'(e.busy));
            chk("dmemaddr", dmemaddr, e.r.alu);
            chk("dmemstore", dmemstore, e.r.sd);
`ifdef EXMEM_FWD_EN
            chk("fwd_valid", 32'(fwd_valid), 32'(e.fv));
            chk("fwd_reg", 32'(fwd_reg), 32'(e.freg));
            chk("fwd_data", fwd_data, e.fdata);
`endif
        end
    end

    task automatic do_reset();
        nRST = 1'b0;
        repeat (3) cyc(rnd());
        nRST = 1'b1;
    endtask

    initial begin
        in_t x;
        m_r    = '0;
        m_pend = 1'b0;
        nRST   = 1'b0;
        vi     = '0;
        @(posedge CLK);
        #1;

        // reset with random inputs, then idle after release
        do_reset();
        x = '0;
        repeat (2) cyc(x);
        chk("post_reset_alu", aluOutport_out, 32'h0);

        // plain ALU op
        x = '0; x.en = 1; x.alu = 32'hA5; x.rd = 5'd8; x.wen = 1;
        cyc(x);
        chk("alu_out", aluOutport_out, 32'hA5);
        chk("alu_rd", 32'(rd_out), 32'd8);
        x.en = 0;
        cyc(x);

        // store with dhit on the third request cycle
        x = '0; x.en = 1; x.mw = 1;
        x.alu = 32'h0F00; x.sd = 32'hDEADBEEF;
        cyc(x);
        chk("st_wen", 32'(dmemWEN), 32'd1);
        chk("st_addr", dmemaddr, 32'h0F00);
        chk("st_data", dmemstore, 32'hDEADBEEF);
        x = '0;
        cyc(x); cyc(x);
        x.dhit = 1;
        cyc(x);
        x.dhit = 0;
        chk("st_wen_done", 32'(dmemWEN), 32'd0);
        repeat (2) cyc(x);

        // flush attempt while busy, then flush advance after dhit
        x = '0; x.en = 1; x.mr = 1; x.alu = 32'h40; x.wen = 1;
        cyc(x);
        x = rnd(); x.en = 1; x.flush = 1; x.dhit = 0;
        cyc(x);
        chk("busy_hold_ren", 32'(dmemREN), 32'd1);
        chk("busy_hold_alu", aluOutport_out, 32'h40);
        x = '0; x.dhit = 1;
        cyc(x);
        x = rnd(); x.en = 1; x.flush = 1; x.dhit = 0;
        cyc(x);
        chk("flush_ctl", 32'({MemRead_out, MemWrite_out,
                              regWEN_out, halt_out}), 32'd0);

        // halt freezes the latch
        x = '0; x.en = 1; x.halt = 1; x.alu = 32'h1234;
        cyc(x);
        for (int i = 0; i < 5; i++) begin
            x = rnd(); x.en = 1; x.halt = 0;
            cyc(x);
        end
        chk("halt_alu", aluOutport_out, 32'h1234);
        do_reset();
        chk("halt_cleared", 32'(halt_out), 32'd0);

        // forwarding sources
        x = '0; x.en = 1; x.jt = 1; x.wen = 1; x.pc = 32'h44;
        cyc(x);
        x = '0; x.en = 1; x.wen = 1; x.rdst = 1; x.rd = 5'd0;
        cyc(x);
        x = '0;
        cyc(x);

        // reset mid-request drops strobes without a clock edge
        x = '0; x.en = 1; x.mw = 1; x.alu = 32'h80;
        cyc(x);
        chk("pre_rst_wen", 32'(dmemWEN), 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("async_rst_wen", 32'(dmemWEN), 32'd0);
        x = '0;
        cyc(x);
        nRST = 1'b1;

        // randomized segments separated by resets
        for (int s = 0; s < 8; s++) begin
            do_reset();
            for (int i = 0; i < 80; i++) cyc(rnd());
        end

        x = '0;
        cyc(x);
        @(negedge CLK);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
